// File: rtl/cam_pkg.sv
// Shared camera-pipeline definitions: sequencer state encoding and the
// width helpers used to size column/row counters from the frame geometry.
package cam_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_VS  = 3'd1,
        S_WAIT_SOF = 3'd2,
        S_ACTIVE   = 3'd3,
        S_DONE     = 3'd4
    } cam_state_e;

    // Beats per line: two pixels are delivered per clock.
    function automatic int cam_bpl(input int frame_width);
        return frame_width / 2;
    endfunction

    function automatic int cam_cw(input int frame_width);
        return (frame_width / 2 > 1) ? $clog2(frame_width / 2) : 1;
    endfunction

    // One extra code so the row counter can rest at FRAME_HEIGHT after eof.
    function automatic int cam_rw(input int frame_height);
        return $clog2(frame_height + 1);
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered-history edge detector: compares the live input against the
// previous-cycle sample so rise/fall are available in the sampling cycle.
module cam_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_d;
        o_rise = i_d & ~prev_q;
        o_fall = ~i_d & prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/cam_line_buffer_ctrl.sv
// Ping-pong line-buffer sequencer: tracks column/row from vsync/valid, drives
// RAM write/read addresses, and flags window, line/frame markers and errors.
module cam_line_buffer_ctrl
    import cam_pkg::*;
#(
    parameter  int FRAME_WIDTH  = 640,
    parameter  int FRAME_HEIGHT = 480,
    localparam int CW           = cam_cw(FRAME_WIDTH),
    localparam int RW           = cam_rw(FRAME_HEIGHT)
) (
    input  logic          i_pclk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic          i_vsync,
    input  logic          i_valid,
    output logic          o_wr_en,
    output logic [CW:0]   o_wr_addr,
    output logic [CW:0]   o_rd_addr,
    output logic          o_win_valid,
    output logic          o_first_col,
    output logic          o_last_col,
    output logic [RW-1:0] o_row,
    output logic          o_sof,
    output logic          o_eol,
    output logic          o_eof,
    output logic          o_err_short,
    output logic          o_err_overrun,
    output logic          o_busy
);

    localparam int            BPL      = cam_bpl(FRAME_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(BPL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(FRAME_HEIGHT);

    cam_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          bank_q, bank_d;
    logic          en_prev_q, en_prev_d;

    logic          wr_en_q, wr_en_d;
    logic [CW:0]   wr_addr_q, wr_addr_d;
    logic [CW:0]   rd_addr_q, rd_addr_d;
    logic          win_q, win_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic [RW-1:0] row_o_q, row_o_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          err_short_q, err_short_d;
    logic          err_ovr_q, err_ovr_d;
    logic          busy_q, busy_d;

    logic          vs_rise, vs_fall;
    logic          frame_end;

    cam_edge_det u_vs_edge (
        .i_clk  (i_pclk),
        .i_rst  (i_rst),
        .i_d    (i_vsync),
        .o_rise (vs_rise),
        .o_fall (vs_fall)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        bank_d      = bank_q;
        en_prev_d   = i_enable;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        win_d       = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        row_o_d     = row_o_q;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        eof_d       = 1'b0;
        err_short_d = err_short_q;
        err_ovr_d   = err_ovr_q;
        frame_end   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    if (!en_prev_q) begin
                        err_short_d = 1'b0;
                        err_ovr_d   = 1'b0;
                    end
                    state_d = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                if (i_vsync) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                // A beat coinciding with the fall is dropped; counting starts next beat.
                if (vs_fall) begin
                    col_d   = '0;
                    row_d   = '0;
                    bank_d  = 1'b0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (i_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {bank_q, col_q};
                    rd_addr_d = {~bank_q, col_q};
                    win_d     = (row_q != '0);
                    first_d   = (col_q == '0);
                    last_d    = (col_q == COL_LAST);
                    row_o_d   = row_q;
                    sof_d     = (row_q == '0) && (col_q == '0);
                    if (col_q == COL_LAST) begin
                        eol_d  = 1'b1;
                        col_d  = '0;
                        bank_d = ~bank_q;
                        if (row_q != ROW_MAX) row_d = row_q + RW'(1);
                        if (row_q == ROW_LAST) begin
                            eof_d     = 1'b1;
                            frame_end = 1'b1;
                            state_d   = S_DONE;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                // The beat above is accounted for before the vsync rise takes effect.
                if (vs_rise) begin
                    if (!frame_end) err_short_d = 1'b1;
                    state_d = i_enable ? S_WAIT_SOF : S_IDLE;
                end
            end
            S_DONE: begin
                if (i_valid) err_ovr_d = 1'b1;
                if (vs_rise) state_d = i_enable ? S_WAIT_SOF : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= 1'b0;
            en_prev_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= {1'b1, {CW{1'b0}}};
            win_q       <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            row_o_q     <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_short_q <= 1'b0;
            err_ovr_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            en_prev_q   <= en_prev_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            win_q       <= win_d;
            first_q     <= first_d;
            last_q      <= last_d;
            row_o_q     <= row_o_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            err_short_q <= err_short_d;
            err_ovr_q   <= err_ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_win_valid   = win_q;
    assign o_first_col   = first_q;
    assign o_last_col    = last_q;
    assign o_row         = row_o_q;
    assign o_sof         = sof_q;
    assign o_eol         = eol_q;
    assign o_eof         = eof_q;
    assign o_err_short   = err_short_q;
    assign o_err_overrun = err_ovr_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_cam_line_buffer_ctrl.sv
// Directed bench for cam_line_buffer_ctrl with an 8x3 frame (4 beats/line).
module tb_cam_line_buffer_ctrl;

    localparam int FW = 8;
    localparam int FH = 3;

    logic       clk = 1'b0;
    logic       rst, en, vs, vld;
    logic       wr_en, win, first_col, last_col, sof, eol, eof;
    logic       err_short, err_ovr, busy;
    logic [2:0] wr_addr, rd_addr;
    logic [1:0] row;

    int n_vec = 0;
    int n_err = 0;

    int exp_wa  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
    int exp_ra  [12] = '{4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
    int exp_row [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    always #5 clk = ~clk;

    cam_line_buffer_ctrl #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
        .i_pclk        (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_vsync       (vs),
        .i_valid       (vld),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_rd_addr     (rd_addr),
        .o_win_valid   (win),
        .o_first_col   (first_col),
        .o_last_col    (last_col),
        .o_row         (row),
        .o_sof         (sof),
        .o_eol         (eol),
        .o_eof         (eof),
        .o_err_short   (err_short),
        .o_err_overrun (err_ovr),
        .o_busy        (busy)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input int k);
        chk($sformatf("b%0d_wr_en", k), wr_en, 1);
        chk($sformatf("b%0d_wr_addr", k), wr_addr, exp_wa[k]);
        chk($sformatf("b%0d_rd_addr", k), rd_addr, exp_ra[k]);
        chk($sformatf("b%0d_row", k), row, exp_row[k]);
        chk($sformatf("b%0d_win", k), win, (k >= 4) ? 1 : 0);
        chk($sformatf("b%0d_sof", k), sof, (k == 0) ? 1 : 0);
        chk($sformatf("b%0d_first", k), first_col, (k % 4 == 0) ? 1 : 0);
        chk($sformatf("b%0d_last", k), last_col, (k % 4 == 3) ? 1 : 0);
        chk($sformatf("b%0d_eol", k), eol, (k % 4 == 3) ? 1 : 0);
        chk($sformatf("b%0d_eof", k), eof, (k == 11) ? 1 : 0);
    endtask

    // vsync high for two clocks, then low; optional beat on the falling cycle.
    task automatic send_frame(input int nb, input int gap, input bit fall_beat);
        vld = 1'b0;
        vs  = 1'b1;
        tick();
        tick();
        vs  = 1'b0;
        vld = fall_beat;
        tick();
        if (fall_beat) chk("fall_beat_ignored", wr_en, 0);
        vld = 1'b0;
        for (int k = 0; k < nb; k++) begin
            vld = 1'b1;
            tick();
            check_beat(k);
            vld = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_wr_en", wr_en, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vs = 1'b0; vld = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 4);
        chk("rst_busy", busy, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_ovr", err_ovr, 0);
        chk("rst_row", row, 0);

        // Enable while a frame is already streaming: nothing written.
        rst = 1'b0; en = 1'b1; vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midframe_wr_en", wr_en, 0);
        end
        chk("midframe_busy", busy, 1);

        send_frame(12, 0, 1'b0);
        vld = 1'b0;
        tick();
        chk("post_eof_pulse", eof, 0);
        chk("nominal_err_short", err_short, 0);
        chk("nominal_err_ovr", err_ovr, 0);

        // Thirteenth beat after eof.
        vld = 1'b1;
        tick();
        chk("overrun_wr_en", wr_en, 0);
        chk("overrun_flag", err_ovr, 1);
        vld = 1'b0;

        send_frame(12, 2, 1'b1);
        chk("gapped_err_short", err_short, 0);
        chk("gapped_ovr_sticky", err_ovr, 1);

        // Short frame: vsync rises after six beats.
        send_frame(6, 0, 1'b0);
        vs = 1'b1;
        tick();
        chk("short_flag", err_short, 1);
        send_frame(12, 0, 1'b0);
        chk("short_still_sticky", err_short, 1);

        // Drop enable: stop at vsync rise, then re-arm clears sticky flags.
        vld = 1'b0; en = 1'b0; vs = 1'b1;
        tick();
        chk("disable_busy", busy, 0);
        chk("disable_err_short", err_short, 1);
        en = 1'b1;
        tick();
        chk("rearm_err_short", err_short, 0);
        chk("rearm_err_ovr", err_ovr, 0);
        chk("rearm_busy", busy, 1);

        // Reset at row 1, column 2.
        send_frame(6, 0, 1'b0);
        rst = 1'b1; vld = 1'b1;
        tick();
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_rd_addr", rd_addr, 4);
        chk("midrst_row", row, 0);
        chk("midrst_win", win, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_wr_en", wr_en, 0);
        end
        vld = 1'b0; vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        vld = 1'b1;
        tick();
        chk("recap_wr_en", wr_en, 1);
        chk("recap_wr_addr", wr_addr, 0);
        chk("recap_sof", sof, 1);
        vld = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
